// File: rtl/enc_pkg.sv
// Shared sizing and FSM state encoding for the 8-to-3 priority encoder.
// One pending request vector is drained one code per accepted handshake.
package enc_pkg;
  localparam int N_IN   = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/msb_find8.sv
// Combinational MSB locator: index of highest set bit and a one-hot flag.
// Zero latency; no flow control.
module msb_find8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       single
);
  always_comb begin
    idx = 3'd0;
    // Ascending scan so the highest set bit wins.
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = 3'(i);
    end
  end

  assign single = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
endmodule

// File: rtl/priority_encoder_8to3.sv
// Accepts a request vector and emits its set-bit indices MSB first, one per handshake.
// First code the cycle after accept; in_ready low while codes are pending, codes hold under out_ready=0.
module priority_encoder_8to3 #(
  parameter int N_IN   = enc_pkg::N_IN,
  parameter int CODE_W = enc_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              zero_drop
);
  import enc_pkg::*;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   pend_q, pend_d;
  logic              zd_q, zd_d;
  logic [CODE_W-1:0] code;
  logic              single;

  // Code and last flag come only from the pending register.
  msb_find8 u_msb (
    .vec    (pend_q),
    .idx    (code),
    .single (single)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|in_vec) begin
            pend_d  = in_vec;
            state_d = BUSY;
          end else begin
            zd_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          pend_d = pend_q & ~(N_IN'(1) << code);
          if (single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zd_q    <= zd_d;
    end
  end

  // Reset masks the handshake outputs immediately, not just after the edge.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == BUSY) && !rst;
  assign zero_drop = zd_q && !rst;
  assign out_code  = code;
  assign out_last  = single;
endmodule
